// File: rtl/mul_hilo_ctrl.sv
// Sequencer for an external combinational 32x32 signed multiplier.
// Latches operands, waits LAT cycles for the product to settle, then
// splits the 64-bit product into the HI/LO register pair. HI/LO can also be
// loaded directly while the sequencer is idle.
module mul_hilo_ctrl #(
    parameter int unsigned LAT = 2
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    output logic [31:0] mul_M,
    output logic [31:0] mul_Q,
    input  logic [63:0] mul_P,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    input  logic        hi_we,
    input  logic        lo_we,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    // Counter preload: WAIT lasts LAT edges, the last one seeing count zero.
    localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_s;
    logic        accept_s;
    logic        capture_s;
    logic        load_hi_s;
    logic        load_lo_s;
    logic [31:0] mul_m_r;
    logic [31:0] mul_q_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        busy_r;
    logic        done_r;

    // Next-state and counter logic for the IDLE/WAIT/CAPTURE sequence.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_WAIT;
                    cnt_s   = CNT_LOAD;
                end else begin
                    state_s = ST_IDLE;
                    cnt_s   = cnt_r;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_CAPTURE;
                    cnt_s   = 4'd0;
                end else begin
                    state_s = ST_WAIT;
                    cnt_s   = cnt_r - 4'd1;
                end
            end
            ST_CAPTURE: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Datapath strobes; start outranks the direct-load enables in IDLE.
    always_comb begin
        accept_s  = (state_r == ST_IDLE) && start;
        capture_s = (state_r == ST_CAPTURE);
        load_hi_s = (state_r == ST_IDLE) && !start && hi_we;
        load_lo_s = (state_r == ST_IDLE) && !start && lo_we;
    end

    // State and wait counter registers.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Operand registers feeding the multiplier; held until the next accept.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            mul_m_r <= 32'd0;
            mul_q_r <= 32'd0;
        end else if (accept_s) begin
            mul_m_r <= opA;
            mul_q_r <= opB;
        end
    end

    // HI/LO: product capture has its own state, otherwise direct loads.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (capture_s) begin
            hi_r <= mul_P[63:32];
            lo_r <= mul_P[31:0];
        end else begin
            if (load_hi_s) begin
                hi_r <= hi_in;
            end
            if (load_lo_s) begin
                lo_r <= lo_in;
            end
        end
    end

    // Status flags registered from the next state so they track state_r.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
            done_r <= capture_s;
        end
    end

    assign mul_M = mul_m_r;
    assign mul_Q = mul_q_r;
    assign HI    = hi_r;
    assign LO    = lo_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Randomized bench for mul_hilo_ctrl with a cycle-level behavioural model.
module tb_mul_hilo_ctrl;

    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic [31:0] opA = 32'd0;
    logic [31:0] opB = 32'd0;
    logic [31:0] mul_M;
    logic [31:0] mul_Q;
    logic [63:0] mul_P;
    logic [31:0] hi_in = 32'd0;
    logic [31:0] lo_in = 32'd0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_fail   = 0;
    int obs_busy = 0;
    int obs_done = 0;

    // Behavioural model state
    int          m_left = 0;
    logic [31:0] m_M = 32'd0;
    logic [31:0] m_Q = 32'd0;
    logic [31:0] m_HI = 32'd0;
    logic [31:0] m_LO = 32'd0;
    logic        m_done = 1'b0;
    logic [63:0] m_prod = 64'd0;

    mul_hilo_ctrl #(.LAT(LAT)) dut (
        .clock(clock), .clear(clear), .start(start),
        .opA(opA), .opB(opB), .mul_M(mul_M), .mul_Q(mul_Q), .mul_P(mul_P),
        .hi_in(hi_in), .lo_in(lo_in), .hi_we(hi_we), .lo_we(lo_we),
        .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    // External combinational multiplier
    assign mul_P = $signed({{32{mul_M[31]}}, mul_M}) * $signed({{32{mul_Q[31]}}, mul_Q});

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_left = 0;
        m_M    = 32'd0;
        m_Q    = 32'd0;
        m_HI   = 32'd0;
        m_LO   = 32'd0;
        m_done = 1'b0;
    endtask

    // One rising edge of the model: a multiply occupies LAT+1 edges.
    task automatic model_edge();
        m_done = 1'b0;
        if (m_left == 0) begin
            if (start) begin
                m_M    = opA;
                m_Q    = opB;
                m_prod = 64'(longint'($signed(opA)) * longint'($signed(opB)));
                m_left = LAT + 1;
            end else begin
                if (hi_we) m_HI = hi_in;
                if (lo_we) m_LO = lo_in;
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_HI   = m_prod[63:32];
                m_LO   = m_prod[31:0];
                m_done = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("hi", 64'(HI), 64'(m_HI));
        check_eq("lo", 64'(LO), 64'(m_LO));
        check_eq("busy", 64'(busy), 64'(m_left != 0));
        check_eq("done", 64'(done), 64'(m_done));
        check_eq("mul_m", 64'(mul_M), 64'(m_M));
        check_eq("mul_q", 64'(mul_Q), 64'(m_Q));
        obs_busy += int'(busy);
        obs_done += int'(done);
    endtask

    // Called at a falling edge: check, drive, take one rising edge, return at next falling edge.
    task automatic step(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic hw, input logic lw,
                        input logic [31:0] hd, input logic [31:0] ld);
        compare_all();
        start = s;
        opA   = a;
        opB   = b;
        hi_we = hw;
        lo_we = lw;
        hi_in = hd;
        lo_in = ld;
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic idle_steps(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Called at a falling edge: asynchronous clear held for n cycles.
    task automatic do_clear(input int n);
        clear = 1'b1;
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (n) @(negedge clock);
        clear = 1'b0;
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom_range(7, 0))
            0: return 32'h80000000;
            1: return 32'hFFFFFFFF;
            2: return 32'h00000000;
            3: return 32'h00000001;
            4: return 32'h7FFFFFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        // Power-on clear
        repeat (2) @(negedge clock);
        model_reset();
        compare_all();
        check_eq("rst_hi", 64'(HI), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        clear = 1'b0;

        // 7*6 with LAT=2: first edge after clear release accepts start
        obs_busy = 0;
        obs_done = 0;
        step(1'b1, 32'd7, 32'd6, 1'b0, 1'b0, 32'd0, 32'd0);
        idle_steps(5);
        check_eq("r035_hi", 64'(HI), 64'h0);
        check_eq("r035_lo", 64'(LO), 64'h2A);
        check_eq("r035_busy_cycles", 64'(obs_busy), 64'd3);
        check_eq("r035_done_cycles", 64'(obs_done), 64'd1);

        // -1 * 1
        step(1'b1, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 32'd0, 32'd0);
        idle_steps(4);
        check_eq("r036_hi", 64'(HI), 64'hFFFFFFFF);
        check_eq("r036_lo", 64'(LO), 64'hFFFFFFFF);

        // most-negative squared
        step(1'b1, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'd0, 32'd0);
        idle_steps(4);
        check_eq("r037_hi", 64'(HI), 64'h40000000);
        check_eq("r037_lo", 64'(LO), 64'h0);

        // second start while busy is ignored
        obs_done = 0;
        step(1'b1, 32'd3, 32'd5, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 32'd9, 32'd11, 1'b0, 1'b0, 32'd0, 32'd0);
        check_eq("r038_mul_m", 64'(mul_M), 64'd3);
        check_eq("r038_mul_q", 64'(mul_Q), 64'd5);
        idle_steps(5);
        check_eq("r038_lo", 64'(LO), 64'd15);
        check_eq("r038_done_cycles", 64'(obs_done), 64'd1);

        // back-to-back: start accepted in the done cycle
        step(1'b1, 32'd4, 32'd4, 1'b0, 1'b0, 32'd0, 32'd0);
        idle_steps(2);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        check_eq("b2b_done", 64'(done), 64'd1);
        step(1'b1, 32'hFFFFFFFE, 32'd8, 1'b0, 1'b0, 32'd0, 32'd0);
        check_eq("b2b_busy", 64'(busy), 64'd1);
        idle_steps(4);
        check_eq("b2b_lo", 64'(LO), 64'hFFFFFFF0);

        // clear aborts a multiply in flight
        step(1'b1, 32'd100, 32'd100, 1'b0, 1'b0, 32'd0, 32'd0);
        idle_steps(1);
        do_clear(1);
        obs_done = 0;
        obs_busy = 0;
        idle_steps(5);
        check_eq("r039_hi", 64'(HI), 64'd0);
        check_eq("r039_lo", 64'(LO), 64'd0);
        check_eq("r039_busy_cycles", 64'(obs_busy), 64'd0);
        check_eq("r039_done_cycles", 64'(obs_done), 64'd0);

        // direct loads in IDLE, ignored while busy
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0, 32'hCAFEF00D);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h12345678, 32'h0);
        check_eq("r040_hi", 64'(HI), 64'h12345678);
        check_eq("r040_lo", 64'(LO), 64'hCAFEF00D);
        step(1'b1, 32'd2, 32'd2, 1'b1, 1'b1, 32'h11111111, 32'h22222222);
        check_eq("r040_start_prio", 64'(HI), 64'h12345678);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF);
        check_eq("r040_busy_hi", 64'(HI), 64'h12345678);
        check_eq("r040_busy_lo", 64'(LO), 64'hCAFEF00D);
        idle_steps(4);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199, 0) == 0) begin
                do_clear(int'($urandom_range(3, 1)));
            end else begin
                step($urandom_range(3, 0) == 0, pick_op(), pick_op(),
                     $urandom_range(2, 0) == 0, $urandom_range(2, 0) == 0,
                     32'($urandom), 32'($urandom));
            end
        end
        idle_steps(5);
        compare_all();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
